// File: rtl/fmps_packet_rx.sv
// Receives header + NUM_DATA_WORDS data beats from an AXI stream, classifies each
// packet (ok / bad magic / short / long) and keeps per-FA-cycle good/bad statistics.
module fmps_packet_rx #(
    parameter int MAGIC_WIDTH     = 16,
    parameter int MAGIC_START_BIT = 16,
    parameter int INDEX_WIDTH     = 5,
    parameter int INDEX_START_BIT = 10,
    parameter int NUM_DATA_WORDS  = 1,
    parameter int COUNT_WIDTH     = 16
) (
    input  logic                           auroraUserClk,
    input  logic                           auroraReset,
    input  logic                           auroraFAstrobe,
    input  logic [MAGIC_WIDTH-1:0]         expectedHeaderMagic,
    input  logic [31:0]                    AXI_STREAM_RX_tdata,
    input  logic                           AXI_STREAM_RX_tvalid,
    input  logic                           AXI_STREAM_RX_tlast,
    output logic                           AXI_STREAM_RX_tready,
    output logic                           packetStrobe,
    output logic [INDEX_WIDTH-1:0]         packetIndex,
    output logic [32*NUM_DATA_WORDS-1:0]   packetData,
    output logic                           statusStrobe,
    output logic [1:0]                     statusCode,
    output logic [COUNT_WIDTH-1:0]         goodCount,
    output logic [COUNT_WIDTH-1:0]         badCount,
    output logic [(2**INDEX_WIDTH)-1:0]    indexSeenMask
);

    localparam int WCW    = (NUM_DATA_WORDS > 1) ? $clog2(NUM_DATA_WORDS) : 1;
    localparam int MASK_W = 2 ** INDEX_WIDTH;
    localparam logic [WCW-1:0] LAST_WORD = WCW'(NUM_DATA_WORDS - 1);

    localparam logic [1:0] CODE_OK    = 2'd0;
    localparam logic [1:0] CODE_MAGIC = 2'd1;
    localparam logic [1:0] CODE_SHORT = 2'd2;
    localparam logic [1:0] CODE_LONG  = 2'd3;

    typedef enum logic [1:0] {
        HEADER = 2'd0,
        DATA   = 2'd1,
        DRAIN  = 2'd2
    } state_t;

    state_t                        state, state_next;
    logic [WCW-1:0]                word_cnt, word_cnt_next;
    logic                          magic_bad, magic_bad_next;
    logic [INDEX_WIDTH-1:0]        hdr_index, hdr_index_next;
    logic [32*NUM_DATA_WORDS-1:0]  payload, payload_next;
    logic                          done;
    logic [1:0]                    done_code;
    logic                          accept;

    logic [COUNT_WIDTH-1:0]        run_good, run_bad;
    logic [MASK_W-1:0]             run_mask, index_bit;
    logic                          good_evt, bad_evt;

    // No back-pressure: ready whenever the block is out of reset.
    assign AXI_STREAM_RX_tready = !auroraReset;
    assign accept = AXI_STREAM_RX_tvalid && AXI_STREAM_RX_tready;

    always_comb begin
        state_next     = state;
        word_cnt_next  = word_cnt;
        magic_bad_next = magic_bad;
        hdr_index_next = hdr_index;
        payload_next   = payload;
        done           = 1'b0;
        done_code      = CODE_OK;
        if (accept) begin
            case (state)
                HEADER: begin
                    magic_bad_next = AXI_STREAM_RX_tdata[MAGIC_START_BIT +: MAGIC_WIDTH]
                                     != expectedHeaderMagic;
                    hdr_index_next = AXI_STREAM_RX_tdata[INDEX_START_BIT +: INDEX_WIDTH];
                    word_cnt_next  = '0;
                    if (AXI_STREAM_RX_tlast) begin
                        done      = 1'b1;
                        done_code = CODE_SHORT;
                    end else begin
                        state_next = DATA;
                    end
                end
                DATA: begin
                    for (int w = 0; w < NUM_DATA_WORDS; w++) begin
                        if (word_cnt == w[WCW-1:0]) begin
                            payload_next[32*w +: 32] = AXI_STREAM_RX_tdata;
                        end
                    end
                    word_cnt_next = word_cnt + 1'b1;
                    if (word_cnt == LAST_WORD) begin
                        if (AXI_STREAM_RX_tlast) begin
                            done       = 1'b1;
                            done_code  = magic_bad ? CODE_MAGIC : CODE_OK;
                            state_next = HEADER;
                        end else begin
                            state_next = DRAIN;
                        end
                    end else if (AXI_STREAM_RX_tlast) begin
                        done       = 1'b1;
                        done_code  = CODE_SHORT;
                        state_next = HEADER;
                    end
                end
                DRAIN: begin
                    if (AXI_STREAM_RX_tlast) begin
                        done       = 1'b1;
                        done_code  = CODE_LONG;
                        state_next = HEADER;
                    end
                end
                default: state_next = HEADER;
            endcase
        end
    end

    always_ff @(posedge auroraUserClk) begin
        if (auroraReset) begin
            state        <= HEADER;
            word_cnt     <= '0;
            magic_bad    <= 1'b0;
            hdr_index    <= '0;
            payload      <= '0;
            statusStrobe <= 1'b0;
            statusCode   <= CODE_OK;
            packetStrobe <= 1'b0;
            packetIndex  <= '0;
            packetData   <= '0;
        end else begin
            state        <= state_next;
            word_cnt     <= word_cnt_next;
            magic_bad    <= magic_bad_next;
            hdr_index    <= hdr_index_next;
            payload      <= payload_next;
            statusStrobe <= done;
            packetStrobe <= done && (done_code == CODE_OK);
            if (done) begin
                statusCode <= done_code;
            end
            // The final data word lands in the same cycle, so take it from payload_next.
            if (done && (done_code == CODE_OK)) begin
                packetIndex <= hdr_index;
                packetData  <= payload_next;
            end
        end
    end

    // Statistics are driven from the registered status pulse, so a completion
    // whose strobe coincides with auroraFAstrobe belongs to the new FA cycle.
    assign good_evt  = statusStrobe && (statusCode == CODE_OK);
    assign bad_evt   = statusStrobe && (statusCode != CODE_OK);
    assign index_bit = MASK_W'(1) << packetIndex;

    always_ff @(posedge auroraUserClk) begin
        if (auroraReset) begin
            run_good      <= '0;
            run_bad       <= '0;
            run_mask      <= '0;
            goodCount     <= '0;
            badCount      <= '0;
            indexSeenMask <= '0;
        end else if (auroraFAstrobe) begin
            goodCount     <= run_good;
            badCount      <= run_bad;
            indexSeenMask <= run_mask;
            run_good      <= good_evt ? COUNT_WIDTH'(1) : '0;
            run_bad       <= bad_evt ? COUNT_WIDTH'(1) : '0;
            run_mask      <= good_evt ? index_bit : '0;
        end else begin
            if (good_evt && !(&run_good)) begin
                run_good <= run_good + 1'b1;
            end
            if (bad_evt && !(&run_bad)) begin
                run_bad <= run_bad + 1'b1;
            end
            if (good_evt) begin
                run_mask <= run_mask | index_bit;
            end
        end
    end

endmodule
